// File: rtl/islemci_cok_dongulu_if.sv
// Instruction handshake bundle for islemci_cok_dongulu.
// master: instruction source, slave: the core.
interface islemci_cok_dongulu_if;
    logic [31:0] buyruk;
    logic        buyruk_gecerli;
    logic        buyruk_hazir;

    modport master (
        output buyruk,
        output buyruk_gecerli,
        input  buyruk_hazir
    );

    modport slave (
        input  buyruk,
        input  buyruk_gecerli,
        output buyruk_hazir
    );
endinterface

// File: rtl/islemci_cok_dongulu.sv
// islemci_cok_dongulu: multi-cycle RV32I-subset core.
// Five-state FSM (AL, COZ, YURUT, BELLEK, YAZ) with a byte-serial data-memory phase.
// Optional feature: define ISLEMCI_MUL_EN to enable the R-type MUL instruction;
// without it that encoding is illegal and sets hata.
module islemci_cok_dongulu #(
    parameter int unsigned YAZMAC_SAYISI   = 32,
    parameter int unsigned BELLEK_DERINLIK = 256,
    parameter logic [31:0] PC_BASLANGIC    = 32'h0000_0000
) (
    input  logic                      saat,
    input  logic                      reset,
    islemci_cok_dongulu_if.slave      bag,
    output logic [31:0]               program_sayaci,
    output logic [31:0]               y_on,
    output logic                      hata
);

    localparam int unsigned YA = $clog2(YAZMAC_SAYISI);
    localparam int unsigned BA = $clog2(BELLEK_DERINLIK);

    typedef enum logic [2:0] {AL, COZ, YURUT, BELLEK, YAZ} durum_t;

    durum_t        durum;
    logic          hazir;
    logic [31:0]   ir;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   imm;
    logic [31:0]   sonuc;
    logic [31:0]   yeni_pc;
    logic          yaz_en;
    logic          bel_oku;
    logic          bel_yaz;
    logic          yasadisi;
    logic [31:0]   veri;
    logic [1:0]    sayac;
    logic [31:0]   yazmac [YAZMAC_SAYISI];
    logic [7:0]    bellek [BELLEK_DERINLIK];

    logic [6:0]    op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [YA-1:0] rs1;
    logic [YA-1:0] rs2;
    logic [YA-1:0] rd;
    logic [BA-1:0] bayt_adr;
    logic [31:0]   toplam;

    logic [31:0]   d_imm;
    logic [31:0]   d_sonuc;
    logic [31:0]   d_yeni_pc;
    logic          d_yaz;
    logic          d_oku;
    logic          d_yazma;
    logic          d_yasadisi;
    logic          dal_alindi;

    assign op       = ir[6:0];
    assign f3       = ir[14:12];
    assign f7       = ir[31:25];
    assign rs1      = ir[15 +: YA];
    assign rs2      = ir[20 +: YA];
    assign rd       = ir[7 +: YA];
    assign toplam   = a + imm;
    assign bayt_adr = sonuc[BA-1:0] + BA'(sayac);

    assign bag.buyruk_hazir = hazir;
    assign y_on             = yazmac[10];

    // Immediate generation from the latched instruction, by format.
    always_comb begin
        d_imm = {{20{ir[31]}}, ir[31:20]};
        case (ir[6:0])
            7'b0100011: d_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: d_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b0110111: d_imm = {ir[31:12], 12'b0};
            default:    d_imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    // Execute-stage decode: ALU result, next PC, memory intent, legality.
    always_comb begin
        d_sonuc    = '0;
        d_yeni_pc  = program_sayaci + 32'd4;
        d_yaz      = 1'b0;
        d_oku      = 1'b0;
        d_yazma    = 1'b0;
        d_yasadisi = 1'b0;
        dal_alindi = 1'b0;
        case (op)
            7'b0110011: begin
                d_yaz = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_sonuc = a + b;
                        3'b001:  d_sonuc = a << b[4:0];
                        3'b010:  d_sonuc = {31'b0, $signed(a) < $signed(b)};
                        3'b100:  d_sonuc = a ^ b;
                        3'b101:  d_sonuc = a >> b[4:0];
                        3'b110:  d_sonuc = a | b;
                        3'b111:  d_sonuc = a & b;
                        default: begin
                            d_yaz      = 1'b0;
                            d_yasadisi = 1'b1;
                        end
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_sonuc = a - b;
`ifdef ISLEMCI_MUL_EN
                end else if (f7 == 7'b0000001 && f3 == 3'b000) begin
                    d_sonuc = a * b;
`endif
                end else begin
                    d_yaz      = 1'b0;
                    d_yasadisi = 1'b1;
                end
            end
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    d_sonuc = toplam;
                    d_yaz   = 1'b1;
                end else begin
                    d_yasadisi = 1'b1;
                end
            end
            7'b0110111: begin
                d_sonuc = imm;
                d_yaz   = 1'b1;
            end
            7'b0000011: begin
                if (f3 == 3'b010) begin
                    d_sonuc = toplam;
                    d_oku   = 1'b1;
                    d_yaz   = 1'b1;
                end else begin
                    d_yasadisi = 1'b1;
                end
            end
            7'b0100011: begin
                if (f3 == 3'b010) begin
                    d_sonuc = toplam;
                    d_yazma = 1'b1;
                end else begin
                    d_yasadisi = 1'b1;
                end
            end
            7'b1100011: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    dal_alindi = (f3 == 3'b000) ? (a == b) : (a != b);
                    if (dal_alindi) begin
                        d_yeni_pc = program_sayaci + imm;
                    end
                end else begin
                    d_yasadisi = 1'b1;
                end
            end
            7'b1100111: begin
                if (f3 == 3'b000) begin
                    d_sonuc   = program_sayaci + 32'd4;
                    d_yeni_pc = toplam & ~32'd1;
                    d_yaz     = 1'b1;
                end else begin
                    d_yasadisi = 1'b1;
                end
            end
            default: d_yasadisi = 1'b1;
        endcase
    end

    // Main FSM: fetch, decode, execute, byte-serial memory, writeback.
    always_ff @(posedge saat) begin
        if (!reset) begin
            durum          <= AL;
            hazir          <= 1'b1;
            program_sayaci <= PC_BASLANGIC;
            hata           <= 1'b0;
            sayac          <= '0;
            ir             <= '0;
            a              <= '0;
            b              <= '0;
            imm            <= '0;
            sonuc          <= '0;
            yeni_pc        <= '0;
            yaz_en         <= 1'b0;
            bel_oku        <= 1'b0;
            bel_yaz        <= 1'b0;
            yasadisi       <= 1'b0;
            veri           <= '0;
            for (int unsigned i = 0; i < YAZMAC_SAYISI; i++) begin
                yazmac[i] <= '0;
            end
        end else begin
            case (durum)
                AL: begin
                    if (bag.buyruk_gecerli) begin
                        ir    <= bag.buyruk;
                        hazir <= 1'b0;
                        durum <= COZ;
                    end
                end
                COZ: begin
                    a     <= yazmac[rs1];
                    b     <= yazmac[rs2];
                    imm   <= d_imm;
                    durum <= YURUT;
                end
                YURUT: begin
                    sonuc    <= d_sonuc;
                    yeni_pc  <= d_yeni_pc;
                    yaz_en   <= d_yaz;
                    bel_oku  <= d_oku;
                    bel_yaz  <= d_yazma;
                    yasadisi <= d_yasadisi;
                    veri     <= b;
                    sayac    <= '0;
                    durum    <= (d_oku || d_yazma) ? BELLEK : YAZ;
                end
                BELLEK: begin
                    // One shift register serves both directions: the store
                    // byte leaves at the bottom while the loaded byte enters
                    // at the top, so after four cycles a load is assembled
                    // little-endian.
                    veri  <= {bellek[bayt_adr], veri[31:8]};
                    sayac <= sayac + 2'd1;
                    if (sayac == 2'd3) begin
                        durum <= YAZ;
                    end
                end
                YAZ: begin
                    if (yasadisi) begin
                        hata <= 1'b1;
                    end
                    if (yaz_en && rd != '0) begin
                        yazmac[rd] <= bel_oku ? veri : sonuc;
                    end
                    program_sayaci <= yeni_pc;
                    hazir          <= 1'b1;
                    durum          <= AL;
                end
                default: begin
                    hazir <= 1'b1;
                    durum <= AL;
                end
            endcase
        end
    end

    // Data memory byte writes; not reset, so bytes written before a reset survive it.
    always_ff @(posedge saat) begin
        if (reset && durum == BELLEK && bel_yaz) begin
            bellek[bayt_adr] <= veri[7:0];
        end
    end

endmodule

// File: tb/tb_islemci_cok_dongulu.sv
// Directed testbench for islemci_cok_dongulu; expectations are hand-computed.
// Honours ISLEMCI_MUL_EN for the MUL expectation.
module tb_islemci_cok_dongulu;

    logic        saat;
    logic        reset;
    logic [31:0] program_sayaci;
    logic [31:0] y_on;
    logic        hata;

    int hata_sayisi;
    int kontrol_sayisi;

    islemci_cok_dongulu_if bag ();

    islemci_cok_dongulu #(
        .YAZMAC_SAYISI   (32),
        .BELLEK_DERINLIK (256),
        .PC_BASLANGIC    (32'h0000_0000)
    ) dut (
        .saat           (saat),
        .reset          (reset),
        .bag            (bag),
        .program_sayaci (program_sayaci),
        .y_on           (y_on),
        .hata           (hata)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    // Single comparison point: counts and reports.
    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got %08h expected %08h", etiket, gozlenen, beklenen);
        end
    endtask

    // Instruction encoders.
    function automatic logic [31:0] kod_i(input logic [31:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] kod_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] kod_s(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] kod_b(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] kod_u(input logic [31:0] im20, input logic [4:0] rd);
        return {im20[19:0], rd, 7'b0110111};
    endfunction

    task automatic saat_bekle();
        @(posedge saat);
        #1;
    endtask

    // Bounded wait for buyruk_hazir.
    task automatic hazir_bekle(input string etiket);
        int n;
        n = 0;
        while (bag.buyruk_hazir !== 1'b1 && n < 20) begin
            saat_bekle();
            n++;
        end
        if (bag.buyruk_hazir !== 1'b1) begin
            kontrol({etiket, "_hazir_zaman"}, {31'b0, bag.buyruk_hazir}, 32'd1);
        end
    endtask

    // Issue one instruction, measure latency, check PC and x10.
    task automatic calistir(input string etiket, input logic [31:0] w, input int gecikme,
                            input logic [31:0] bek_pc, input logic [31:0] bek_y);
        int n;
        hazir_bekle(etiket);
        bag.buyruk         = w;
        bag.buyruk_gecerli = 1'b1;
        saat_bekle();
        bag.buyruk_gecerli = 1'b0;
        bag.buyruk         = 32'h0000_0013;
        n = 0;
        while (bag.buyruk_hazir !== 1'b1 && n < 20) begin
            saat_bekle();
            n++;
        end
        kontrol({etiket, "_gecikme"}, n, gecikme);
        kontrol({etiket, "_pc"}, program_sayaci, bek_pc);
        kontrol({etiket, "_y_on"}, y_on, bek_y);
    endtask

    logic [31:0] y_mul;
    logic [31:0] hata_mul;

    initial begin
        hata_sayisi        = 0;
        kontrol_sayisi     = 0;
        reset              = 1'b0;
        bag.buyruk         = kod_i(32'd5, 5'd0, 3'b000, 5'd10, 7'b0010011);
        bag.buyruk_gecerli = 1'b1;
`ifdef ISLEMCI_MUL_EN
        y_mul    = 32'd9;
        hata_mul = 32'd0;
`else
        y_mul    = 32'h0000_0054;
        hata_mul = 32'd1;
`endif

        // Reset held with a valid instruction offered: nothing is accepted.
        repeat (3) saat_bekle();
        kontrol("rst_hazir", {31'b0, bag.buyruk_hazir}, 32'd1);
        kontrol("rst_pc", program_sayaci, 32'h0);
        kontrol("rst_y_on", y_on, 32'h0);
        kontrol("rst_hata", {31'b0, hata}, 32'd0);
        reset              = 1'b1;
        bag.buyruk_gecerli = 1'b0;
        saat_bekle();
        kontrol("rst_sonra_hazir", {31'b0, bag.buyruk_hazir}, 32'd1);
        kontrol("rst_sonra_pc", program_sayaci, 32'h0);

        // ADDI sequence.
        calistir("addi5",  kod_i(32'd5, 5'd0, 3'b000, 5'd10, 7'b0010011), 3, 32'h04, 32'd5);
        calistir("addim7", kod_i(-32'sd7, 5'd10, 3'b000, 5'd10, 7'b0010011), 3, 32'h08, 32'hFFFF_FFFE);

        // Clear memory words 0 and 4, build 0x12345678 in x1, store/load at 1.
        calistir("sw0",  kod_s(32'd0, 5'd0, 5'd0), 7, 32'h0C, 32'hFFFF_FFFE);
        calistir("sw4",  kod_s(32'd4, 5'd0, 5'd0), 7, 32'h10, 32'hFFFF_FFFE);
        calistir("lui",  kod_u(32'h12345, 5'd1), 3, 32'h14, 32'hFFFF_FFFE);
        calistir("addi678", kod_i(32'h678, 5'd1, 3'b000, 5'd1, 7'b0010011), 3, 32'h18, 32'hFFFF_FFFE);
        calistir("sw1",  kod_s(32'd1, 5'd1, 5'd0), 7, 32'h1C, 32'hFFFF_FFFE);
        calistir("lw1",  kod_i(32'd1, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h20, 32'h1234_5678);
        calistir("lw0",  kod_i(32'd0, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h24, 32'h3456_7800);
        calistir("lw2",  kod_i(32'd2, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h28, 32'h0012_3456);

        // Store at 254 wraps bytes 2,3 to addresses 0,1.
        calistir("sw254", kod_s(32'd254, 5'd1, 5'd0), 7, 32'h2C, 32'h0012_3456);
        calistir("lw254", kod_i(32'd254, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h30, 32'h1234_5678);
        calistir("lw0b",  kod_i(32'd0, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h34, 32'h3456_1234);

        // Branches and JALR.
        calistir("x1_3", kod_i(32'd3, 5'd0, 3'b000, 5'd1, 7'b0010011), 3, 32'h38, 32'h3456_1234);
        calistir("x2_3", kod_i(32'd3, 5'd0, 3'b000, 5'd2, 7'b0010011), 3, 32'h3C, 32'h3456_1234);
        calistir("beq",  kod_b(32'd16, 5'd2, 5'd1, 3'b000), 3, 32'h4C, 32'h3456_1234);
        calistir("bne",  kod_b(32'd16, 5'd2, 5'd1, 3'b001), 3, 32'h50, 32'h3456_1234);
        calistir("jalr", kod_i(32'd4, 5'd1, 3'b000, 5'd10, 7'b1100111), 3, 32'h06, 32'h0000_0054);
        calistir("bne_geri", kod_b(-32'sd4, 5'd0, 5'd1, 3'b001), 3, 32'h02, 32'h0000_0054);
        kontrol("hata_temiz", {31'b0, hata}, 32'd0);

        // MUL (config dependent), then an illegal word.
        calistir("mul", kod_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd10), 3, 32'h06, y_mul);
        kontrol("mul_hata", {31'b0, hata}, hata_mul);
        calistir("yasadisi", 32'hFFFF_FFFF, 3, 32'h0A, y_mul);
        kontrol("yasadisi_hata", {31'b0, hata}, 32'd1);

        // R-type coverage with x1=3, x2=3, x3=-1.
        calistir("x3_m1", kod_i(-32'sd1, 5'd0, 3'b000, 5'd3, 7'b0010011), 3, 32'h0E, y_mul);
        calistir("slt", kod_r(7'b0000000, 5'd1, 5'd3, 3'b010, 5'd10), 3, 32'h12, 32'h0000_0001);
        calistir("srl", kod_r(7'b0000000, 5'd1, 5'd3, 3'b101, 5'd10), 3, 32'h16, 32'h1FFF_FFFF);
        calistir("sll", kod_r(7'b0000000, 5'd1, 5'd1, 3'b001, 5'd10), 3, 32'h1A, 32'h0000_0018);
        calistir("xor", kod_r(7'b0000000, 5'd1, 5'd3, 3'b100, 5'd10), 3, 32'h1E, 32'hFFFF_FFFC);
        calistir("sub", kod_r(7'b0100000, 5'd3, 5'd1, 3'b000, 5'd10), 3, 32'h22, 32'h0000_0004);
        calistir("and", kod_r(7'b0000000, 5'd1, 5'd3, 3'b111, 5'd10), 3, 32'h26, 32'h0000_0003);
        calistir("add", kod_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd10), 3, 32'h2A, 32'h0000_0006);
        calistir("or",  kod_r(7'b0000000, 5'd3, 5'd1, 3'b110, 5'd10), 3, 32'h2E, 32'hFFFF_FFFF);
        calistir("x0_yaz", kod_i(32'd5, 5'd0, 3'b000, 5'd0, 7'b0010011), 3, 32'h32, 32'hFFFF_FFFF);
        calistir("x0_oku", kod_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd10), 3, 32'h36, 32'h0000_0000);

        // Store interrupted by reset after two bytes.
        calistir("sw40_sifir", kod_s(32'h40, 5'd0, 5'd0), 7, 32'h3A, 32'h0);
        calistir("lui4", kod_u(32'h12345, 5'd4), 3, 32'h3E, 32'h0);
        calistir("addi4", kod_i(32'h678, 5'd4, 3'b000, 5'd4, 7'b0010011), 3, 32'h42, 32'h0);
        hazir_bekle("sw_kes");
        bag.buyruk         = kod_s(32'h40, 5'd4, 5'd0);
        bag.buyruk_gecerli = 1'b1;
        saat_bekle();
        bag.buyruk_gecerli = 1'b0;
        repeat (4) saat_bekle();
        reset              = 1'b0;
        bag.buyruk         = kod_i(32'd5, 5'd0, 3'b000, 5'd10, 7'b0010011);
        bag.buyruk_gecerli = 1'b1;
        saat_bekle();
        kontrol("kes_hazir", {31'b0, bag.buyruk_hazir}, 32'd1);
        kontrol("kes_pc", program_sayaci, 32'h0);
        kontrol("kes_y_on", y_on, 32'h0);
        kontrol("kes_hata", {31'b0, hata}, 32'd0);
        saat_bekle();
        kontrol("kes_tut_pc", program_sayaci, 32'h0);
        kontrol("kes_tut_y_on", y_on, 32'h0);
        reset              = 1'b1;
        bag.buyruk_gecerli = 1'b0;
        saat_bekle();
        calistir("kes_lw", kod_i(32'h40, 5'd0, 3'b010, 5'd10, 7'b0000011), 7, 32'h04, 32'h0000_5678);
        calistir("kes_yazmac", kod_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd10), 3, 32'h08, 32'h0);

        $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/islemci_cok_dongulu.md
# islemci_cok_dongulu

Multi-cycle, parametrised RV32I-subset processor core; the successor of the team's single-cycle core. Instructions arrive over a valid/ready handshake and are executed through a five-state FSM with a byte-serial data-memory phase. The register file size, data-memory depth and reset PC are parameters; the instruction set is extended with logic, compare and branch operations; illegal opcodes are flagged.

## Interface
- YAZMAC_SAYISI, 32: architectural registers, 16 or 32; rs/rd indices are masked to log2(YAZMAC_SAYISI) bits.
- BELLEK_DERINLIK, 256: data memory size in bytes, power of two.
- PC_BASLANGIC, 32'h0000_0000: program counter value after reset.
- saat  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- buyruk  input  32  instruction word.
- buyruk_gecerli  input  1  buyruk is valid.
- buyruk_hazir  output  1  core accepts an instruction this cycle.
- program_sayaci  output  32  PC of the next instruction to be fetched.
- y_on  output  32  contents of register x10.
- hata  output  1  sticky illegal-instruction flag.

## Operation
- FSM states: AL (fetch), COZ (decode), YURUT (execute), BELLEK (memory), YAZ (writeback).
- AL: buyruk_hazir=1. If buyruk_gecerli=1, latch buyruk and go to COZ; otherwise stay in AL.
- COZ: read rs1 and rs2; build the sign-extended I/S/B/U immediate; go to YURUT.
- YURUT: ALU result, branch decision and target, or memory address. LW and SW go to BELLEK; everything else goes to YAZ.
- BELLEK: 2-bit byte counter, 4 cycles, little-endian. Byte k is at address (adr+k) mod BELLEK_DERINLIK. Misaligned addresses are legal and wrap. Then go to YAZ.
- YAZ: write rd (writes to x0 are discarded; x0 always reads 0); update the PC; go to AL.
- R-type (0110011), decoded by funct3/funct7: ADD 000/0000000, SUB 000/0100000, SLL 001, SLT 010 (signed), XOR 100, SRL 101/0000000, OR 110, AND 111. Shift amount is rs2[4:0].
- ADDI (0010011, funct3 000): rd = rs1 + sext(imm12).
- LUI (0110111): rd = {imm20, 12'b0}.
- LW (0000011/010): rd = mem[rs1+sext(imm)].
- SW (0100011/010): mem[rs1+sext(imm)] = rs2.
- BEQ (1100011/000), BNE (1100011/001):
  - taken: PC = PC + sext({imm12, 1'b0});
  - not taken: PC = PC + 4.
- JALR (1100111/000): rd = PC+4; PC = (rs1 + sext(imm)) & ~1. rs1 is read before rd is written, so rd==rs1 is correct.
- All other instructions: PC = PC + 4.
- Arithmetic is modulo 2^32; the PC wraps modulo 2^32.
- Illegal instruction (any opcode/funct combination not listed): hata is set, no register or memory write, PC = PC + 4. hata clears only on reset.
- Reset (reset=0 at a rising edge), effective that edge regardless of state:
  - state = AL, PC = PC_BASLANGIC, all registers = 0, hata = 0, byte counter = 0;
  - buyruk_hazir reads 1 in the cycle after reset deasserts;
  - data memory is not reset (simulation initial value 0);
  - a store interrupted mid-BELLEK keeps the bytes already written.

## Timing
- Output reset values: buyruk_hazir=1, program_sayaci=PC_BASLANGIC, y_on=0, hata=0.
- Accept edge: the edge at which buyruk_hazir && buyruk_gecerli.
- Non-memory instruction: 3 cycles after the accept edge; buyruk_hazir is 1 again in the 4th cycle. Register and PC results are visible in that same cycle.
- LW/SW: 7 cycles after the accept edge.
- buyruk is sampled only at the accept edge; buyruk_gecerli is ignored outside AL.
- Store bytes become visible one per cycle during BELLEK.
- y_on and program_sayaci are registered outputs and update at the YAZ edge.
- With reset held low, the core accepts nothing: buyruk_hazir stays 1 but no instruction is latched.

## Configuration
- ISLEMCI_MUL_EN defined: MUL is supported (R-type, funct7=0000001, funct3=000) and writes the low 32 bits of rs1*rs2. Same latency as the other R-type ops.
- ISLEMCI_MUL_EN undefined: that encoding is illegal and sets hata.

## Test plan
- Reset, then ADDI x10,x0,5 followed by ADDI x10,x10,-7 -> y_on=5, then 32'hFFFF_FFFE; program_sayaci=8; each instruction accepted 4 cycles apart.
- LUI x1,0x12345, ADDI x1,x1,0x678, SW x1,1(x0), LW x10,1(x0) -> y_on=32'h1234_5678; the SW/LW pair takes 16 cycles; bytes 1..4 of memory = 78,56,34,12.
- SW at address BELLEK_DERINLIK-2 -> the upper two bytes wrap to addresses 0 and 1; a LW from the same address returns the same word.
- x1=3, x2=3: BEQ x1,x2,+16 -> PC+16. BNE x1,x2,+16 -> PC+4. JALR x10,x1,4 at PC=0x20 -> y_on=0x24, PC=0x6 (bit 0 cleared from 0x7).
- Illegal word 32'hFFFF_FFFF -> hata=1, PC+4, no register change. MUL x10,x1,x2 with x1=x2=3 -> y_on=9 with ISLEMCI_MUL_EN defined; hata=1 without it.
- Assert reset low during BELLEK of a SW -> the next edge is in AL with PC=PC_BASLANGIC, registers=0, hata=0; earlier-written bytes are retained; buyruk_gecerli held high during reset is not accepted.
